seg_display_scan: RTL and testbench

- Time-multiplexed 8-digit seven-segment display driver. It is the output-side counterpart of the keypad matrix scanner: the scanner drives columns and samples rows, while this block drives one-hot anodes and segment lines.
- It takes per-digit hex codes, decimal points, enable mask and blink mask from the core logic.
- New values are double-buffered and only applied at frame boundaries, so no partial frames are ever displayed.
- Sits between the application FSM and the board display pins.

---
 rtl/seg_display_scan.sv | 158 +++++++++++++++
 tb/tb_seg_display_scan.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// seg_display_scan
//   Time-multiplexed seven-segment driver for DIGITS digits. New display values
//   are captured into a pending buffer on load. They are promoted to the active
//   buffer only at a frame boundary, so a partial frame is never shown.
//
// Ports
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   load       : single-cycle strobe; captures data/dp/en_mask/blink_mask
//   data       : 4-bit hex code per digit, digit i = data[4i+3:4i]
//   dp         : decimal point per digit, 1 = lit
//   en_mask    : digit enable, 1 = shown
//   blink_mask : 1 = digit blinks
//   pending    : captured values are waiting for the next frame boundary
//   an         : one-hot (or all-zero) active-high anode select
//   seg        : active-high segments {dp,g,f,e,d,c,b,a}
module seg_display_scan #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 125
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     en_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic                  pending,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg
);

  localparam int unsigned DIV_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [FRM_W-1:0]    frame_cnt;
  logic                blink_phase;

  logic [4*DIGITS-1:0] data_pnd, data_act;
  logic [DIGITS-1:0]   dp_pnd, dp_act;
  logic [DIGITS-1:0]   en_pnd, en_act;
  logic [DIGITS-1:0]   blink_pnd, blink_act;

  logic                tick;
  logic                frame_end;
  logic                visible;
  logic [3:0]          cur_code;
  logic [DIGITS-1:0]   an_next;
  logic [7:0]          seg_next;

  function automatic logic [6:0] hex_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick      = (div_cnt == DIV_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  // Next-cycle anode/segment values for the digit currently addressed by idx.
  always_comb begin
    an_next  = '0;
    seg_next = '0;
    cur_code = data_act[4*int'(idx) +: 4];
    visible  = en_act[idx] && !(blink_act[idx] && blink_phase);
    if (visible) begin
      an_next[idx] = 1'b1;
      seg_next     = {dp_act[idx], hex_decode(cur_code)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      pending     <= 1'b0;
      data_pnd    <= '0;
      dp_pnd      <= '0;
      en_pnd      <= '0;
      blink_pnd   <= '0;
      data_act    <= '0;
      dp_act      <= '0;
      en_act      <= '0;
      blink_act   <= '0;
      an          <= '0;
      seg         <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;

      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      if (frame_end) begin
        if (frame_cnt == FRM_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      // A load on the boundary cycle bypasses the pending buffer so the
      // newest values win over anything captured earlier.
      if (frame_end) begin
        if (load) begin
          data_act  <= data;
          dp_act    <= dp;
          en_act    <= en_mask;
          blink_act <= blink_mask;
        end else if (pending) begin
          data_act  <= data_pnd;
          dp_act    <= dp_pnd;
          en_act    <= en_pnd;
          blink_act <= blink_pnd;
        end
        pending <= 1'b0;
      end else if (load) begin
        data_pnd  <= data;
        dp_pnd    <= dp;
        en_pnd    <= en_mask;
        blink_pnd <= blink_mask;
        pending   <= 1'b1;
      end

      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan
//   Directed bench for seg_display_scan with DIGITS=8, SCAN_DIV=4, BLINK_DIV=2
//   (one frame = 32 clocks). k counts clock edges since reset release, so frame
//   boundaries land on edges k = 32*m and digit s of a frame is driven on the
//   outputs after edges 32*m+4*s+1 .. 32*m+4*s+4.
module tb_seg_display_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  en_mask = '0;
  logic [7:0]  blink_mask = '0;
  logic        pending;
  logic [7:0]  an;
  logic [7:0]  seg;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned k        = 0;

  seg_display_scan #(.DIGITS(8), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .dp         (dp),
    .en_mask    (en_mask),
    .blink_mask (blink_mask),
    .pending    (pending),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", tag, k, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0;
    k++;
    check("an_onehot0", 64'($onehot0(an)), 64'd1);
  endtask

  task automatic advance_to(input int unsigned target);
    while (k < target) step();
  endtask

  task automatic drive_load(input logic [31:0] d, input logic [7:0] p,
                            input logic [7:0] e, input logic [7:0] b);
    data       = d;
    dp         = p;
    en_mask    = e;
    blink_mask = b;
    load       = 1'b1;
  endtask

  // Steps through one full frame starting at a boundary and checks every cycle.
  // segs holds the expected segment byte of digit s at [8*s +: 8]; ens marks the
  // digits expected lit. An optional load is driven when k equals ld_at.
  task automatic check_frame(input logic [63:0] segs, input logic [7:0] ens,
                             input int ld_at, input logic [31:0] ld_d,
                             input logic [7:0] ld_dp, input logic [7:0] ld_en,
                             input logic [7:0] ld_bl);
    logic [7:0] exp_an;
    logic [7:0] exp_seg;
    for (int j = 0; j < 32; j++) begin
      if (ld_at >= 0 && k == ld_at) drive_load(ld_d, ld_dp, ld_en, ld_bl);
      step();
      exp_an  = '0;
      exp_seg = '0;
      if (ens[j/4]) begin
        exp_an[j/4] = 1'b1;
        exp_seg     = segs[8*(j/4) +: 8];
      end
      check("frame_an", 64'(an), 64'(exp_an));
      check("frame_seg", 64'(seg), 64'(exp_seg));
    end
  endtask

  initial begin
    // Reset held for three edges.
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst_an", 64'(an), 64'h0);
    check("rst_seg", 64'(seg), 64'h0);
    check("rst_pending", 64'(pending), 64'h0);
    rst = 1'b0;
    k   = 0;

    for (int i = 0; i < 64; i++) begin
      step();
      check("idle_an", 64'(an), 64'h0);
      check("idle_seg", 64'(seg), 64'h0);
      check("idle_pending", 64'(pending), 64'h0);
    end

    // Mid-frame load; pending holds until the boundary at k=96.
    advance_to(74);
    drive_load(32'h76543210, 8'h01, 8'hFF, 8'h00);
    step();
    check("pend_set", 64'(pending), 64'h1);
    advance_to(95);
    check("pend_hold", 64'(pending), 64'h1);
    check("dark_before_apply", 64'(an), 64'h0);
    step();
    check("pend_clear", 64'(pending), 64'h0);

    // Frame 96..128 shows 0..7 with dp on digit 0; enable mask 0xA5 staged at k=100.
    check_frame(64'h077D6D664F5B06BF, 8'hFF, 100, 32'h76543210, 8'h00, 8'hA5, 8'h00);
    // Frame 128..160: digits 1,3,4,6 dark; blink setup staged at k=140.
    check_frame(64'h077D6D664F5B063F, 8'hA5, 140, 32'h0000000F, 8'h00, 8'h01, 8'h01);

    // Blink phase after boundaries 160,192,224,256,288 is 0,1,1,0,0.
    check_frame(64'h0000000000000071, 8'h01, -1, '0, '0, '0, '0);
    check_frame(64'h0000000000000071, 8'h00, -1, '0, '0, '0, '0);
    check_frame(64'h0000000000000071, 8'h00, -1, '0, '0, '0, '0);
    check_frame(64'h0000000000000071, 8'h01, -1, '0, '0, '0, '0);
    check_frame(64'h0000000000000071, 8'h01, -1, '0, '0, '0, '0);

    // Overwrite: A then B before the boundary at 352; only B may appear.
    advance_to(330);
    drive_load(32'h11111111, 8'h00, 8'hFF, 8'h00);
    step();
    advance_to(340);
    drive_load(32'h22222222, 8'hFF, 8'hFF, 8'h00);
    step();
    check("pend_overwrite", 64'(pending), 64'h1);
    advance_to(352);
    // Collision: C is loaded on the frame_end cycle (edge 384).
    check_frame(64'hDBDBDBDBDBDBDBDB, 8'hFF, 383, 32'h89ABCDEF, 8'h80, 8'hFF, 8'h00);
    check("pend_collision", 64'(pending), 64'h0);
    check_frame(64'hFF6F777C395E7971, 8'hFF, -1, '0, '0, '0, '0);

    // Reset during slot 5 with a load pending.
    advance_to(433);
    drive_load(32'h00000000, 8'h00, 8'hFF, 8'h00);
    step();
    check("pend_before_rst", 64'(pending), 64'h1);
    advance_to(437);
    check("slot5_an", 64'(an), 64'h20);
    check("slot5_seg", 64'(seg), 64'h77);
    rst = 1'b1;
    step();
    check("midrst_an", 64'(an), 64'h0);
    check("midrst_seg", 64'(seg), 64'h0);
    check("midrst_pending", 64'(pending), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      check("post_rst_an", 64'(an), 64'h0);
      check("post_rst_seg", 64'(seg), 64'h0);
      check("post_rst_pending", 64'(pending), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
